// File: rtl/mem_pkg.sv
// mem_pkg: access size encodings and print engine state encoding shared by the data memory unit
package mem_pkg;
   localparam logic [1:0] SZ_BYTE = 2'd0;
   localparam logic [1:0] SZ_HALF = 2'd1;
   localparam logic [1:0] SZ_WORD = 2'd2;
   typedef enum logic [2:0] {P_IDLE, P_FETCH, P_WAIT, P_EMIT, P_DONE} pstate_t;
endpackage

// File: rtl/mem_array.sv
// mem_array: single-port synchronous RAM, 32-bit words, 4 byte enables, registered read
// ports: clk; en access enable; we write enable; be byte lanes; addr word index; wdata lane-replicated store data; rdata registered read data
module mem_array #(
   parameter int DEPTH = 1024,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          en,
   input  logic          we,
   input  logic [3:0]    be,
   input  logic [AW-1:0] addr,
   input  logic [31:0]   wdata,
   output logic [31:0]   rdata
);
   logic [31:0] mem [DEPTH];
   always_ff @(posedge clk)
      if (en) begin
         for (int i = 0; i < 4; i++)
            if (we && be[i]) mem[addr][i*8 +: 8] <= wdata[i*8 +: 8];
         rdata <= mem[addr];
      end
endmodule

// File: rtl/dmem_unit.sv
// dmem_unit: CPU data memory with sized/signed loads and byte-lane stores, plus a NUL-terminated string print engine
// ports: clk/rst; req_* CPU access in, rd_valid/rd_data/err response one cycle later;
//        print_start/print_addr job start, print_busy, char_valid/char_ready/char_data stream, print_done/print_err end of job
module dmem_unit
   import mem_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR   = 32'h1000_0000,
   parameter int          DEPTH_WORDS = 1024,
   parameter int          MAX_STR     = 256
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   input  logic        req_write,
   input  logic [1:0]  req_size,
   input  logic        req_signed,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        rd_valid,
   output logic [31:0] rd_data,
   output logic        err,
   input  logic        print_start,
   input  logic [31:0] print_addr,
   output logic        print_busy,
   output logic        char_valid,
   input  logic        char_ready,
   output logic [7:0]  char_data,
   output logic        print_done,
   output logic        print_err
);
   localparam int          AW   = $clog2(DEPTH_WORDS);
   localparam int          CW   = $clog2(MAX_STR + 1);
   localparam logic [31:0] SPAN = 32'(4 * DEPTH_WORDS);

   pstate_t        state, nxt;
   logic [31:0]    c_off, p_off, p_addr, rdata, ram_wdata, shifted, ext;
   logic [3:0]     be;
   logic [AW-1:0]  ram_addr;
   logic [CW-1:0]  cnt;
   logic [7:0]     p_byte, char_q;
   logic [1:0]     sz_q, lane_q;
   logic           c_ok, p_in, fetch_go, latch, step, set_err;
   logic           rv_q, err_q, ld_q, sg_q, perr_q;

   // below-base addresses wrap to huge offsets, so one unsigned compare covers both bounds
   assign c_off = req_addr - BASE_ADDR;
   assign p_off = p_addr - BASE_ADDR;
   assign p_in  = p_off < SPAN;
   assign c_ok  = c_off < SPAN && req_size != 2'd3
                  && !(req_size == SZ_HALF && req_addr[0])
                  && !(req_size == SZ_WORD && req_addr[1:0] != 2'd0);

   assign be        = req_size == SZ_BYTE ? 4'b0001 << req_addr[1:0] :
                      req_size == SZ_HALF ? 4'b0011 << req_addr[1:0] : 4'b1111;
   assign ram_wdata = req_size == SZ_BYTE ? {4{req_wdata[7:0]}} :
                      req_size == SZ_HALF ? {2{req_wdata[15:0]}} : req_wdata;
   // CPU owns the port whenever it asks; the print engine only reads in idle CPU cycles
   assign ram_addr  = req_valid ? c_off[AW+1:2] : p_off[AW+1:2];

   mem_array #(.DEPTH(DEPTH_WORDS)) u_ram (
      .clk  (clk),
      .en   (req_valid | fetch_go),
      .we   (req_valid & req_write & c_ok & ~rst),
      .be   (be),
      .addr (ram_addr),
      .wdata(ram_wdata),
      .rdata(rdata)
   );

   always_ff @(posedge clk)
      if (rst) begin
         rv_q  <= 1'b0;
         err_q <= 1'b0;
         ld_q  <= 1'b0;
      end else begin
         rv_q   <= req_valid;
         err_q  <= req_valid & ~c_ok;
         ld_q   <= req_valid & ~req_write & c_ok;
         sz_q   <= req_size;
         sg_q   <= req_signed;
         lane_q <= req_addr[1:0];
      end

   assign shifted  = rdata >> {lane_q, 3'b000};
   assign ext      = sz_q == SZ_BYTE ? {{24{sg_q & shifted[7]}}, shifted[7:0]} :
                     sz_q == SZ_HALF ? {{16{sg_q & shifted[15]}}, shifted[15:0]} : shifted;
   assign rd_valid = rv_q;
   assign err      = err_q;
   assign rd_data  = ld_q ? ext : 32'd0;

   assign p_byte = rdata[{p_addr[1:0], 3'b000} +: 8];

   always_comb begin
      nxt      = state;
      fetch_go = 1'b0;
      latch    = 1'b0;
      step     = 1'b0;
      set_err  = 1'b0;
      unique case (state)
         P_IDLE:  nxt = print_start ? P_FETCH : P_IDLE;
         P_FETCH:
            if (cnt == CW'(MAX_STR) || !p_in) begin
               nxt     = P_DONE;
               set_err = 1'b1;
            end else if (!req_valid) begin
               fetch_go = 1'b1;
               nxt      = P_WAIT;
            end
         P_WAIT: begin
            latch = p_byte != 8'd0;
            nxt   = latch ? P_EMIT : P_DONE;
         end
         P_EMIT:
            if (char_ready) begin
               step = 1'b1;
               nxt  = P_FETCH;
            end
         P_DONE:  nxt = P_IDLE;
         default: nxt = P_IDLE;
      endcase
   end

   always_ff @(posedge clk)
      if (rst) begin
         state  <= P_IDLE;
         char_q <= 8'd0;
         perr_q <= 1'b0;
         p_addr <= 32'd0;
         cnt    <= '0;
      end else begin
         state <= nxt;
         if (state == P_IDLE && print_start) begin
            p_addr <= print_addr;
            cnt    <= '0;
            perr_q <= 1'b0;
         end
         if (step) begin
            p_addr <= p_addr + 32'd1;
            cnt    <= cnt + 1'b1;
         end
         if (latch) char_q <= p_byte;
         if (set_err) perr_q <= 1'b1;
      end

   assign print_busy = state != P_IDLE;
   assign char_valid = state == P_EMIT;
   assign char_data  = char_q;
   assign print_done = state == P_DONE;
   assign print_err  = print_done & perr_q;
endmodule

// File: tb/tb_dmem_unit.sv
// tb_dmem_unit: directed vector table for CPU accesses plus hand-written print engine sequences
module tb_dmem_unit;
   localparam logic [31:0] B = 32'h1000_0000;

   logic        clk = 1'b0, rst = 1'b1;
   logic        req_valid = 1'b0, req_write = 1'b0, req_signed = 1'b0;
   logic [1:0]  req_size = 2'd0;
   logic [31:0] req_addr = 32'd0, req_wdata = 32'd0;
   logic        rd_valid, err;
   logic [31:0] rd_data;
   logic        print_start = 1'b0, char_ready = 1'b0;
   logic [31:0] print_addr = 32'd0;
   logic        print_busy, char_valid, print_done, print_err;
   logic [7:0]  char_data;

   int total = 0, passed = 0;

   dmem_unit dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_write(req_write), .req_size(req_size), .req_signed(req_signed),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .rd_valid(rd_valid), .rd_data(rd_data), .err(err),
      .print_start(print_start), .print_addr(print_addr), .print_busy(print_busy),
      .char_valid(char_valid), .char_ready(char_ready), .char_data(char_data),
      .print_done(print_done), .print_err(print_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        wr;
      logic [1:0]  sz;
      logic        sg;
      logic [31:0] a;
      logic [31:0] wd;
      logic        e;
      logic [31:0] d;
   } vec_t;

   vec_t v [20];

   task automatic chk(input string n, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got === exp) passed++;
      else $display("FAIL %s: got %h expected %h", n, got, exp);
   endtask

   task automatic access(input logic wr, input logic [1:0] sz, input logic sg, input logic [31:0] a,
                         input logic [31:0] wd, output logic [33:0] resp);
      @(negedge clk);
      req_valid = 1'b1; req_write = wr; req_size = sz; req_signed = sg; req_addr = a; req_wdata = wd;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      resp = {rd_valid, err, rd_data};
   endtask

   task automatic print_job(input string tag, input logic [31:0] a, input int stall, input int loads,
                            input logic [31:0] exp_load, input logic [31:0] exp_chars, input int exp_n,
                            input logic exp_err);
      logic [7:0] got [8];
      int n = 0, nst = 0, viol = 0, resps = 0, bad = 0;
      logic done = 1'b0, gerr = 1'b0, hold = 1'b0;
      logic [7:0] hdata = 8'd0;
      for (int i = 0; i < 8; i++) got[i] = 8'd0;
      @(negedge clk);
      print_start = 1'b1; print_addr = a; char_ready = 1'b1;
      for (int c = 0; c < 300 && !done; c++) begin
         @(negedge clk);
         print_start = 1'b0;
         if (rd_valid) begin
            resps++;
            if (rd_data !== exp_load || err) bad++;
         end
         if (hold && (!char_valid || char_data !== hdata)) viol++;
         char_ready = !(char_valid && char_data == 8'h69 && nst < stall);
         if (!char_ready) nst++;
         if (char_valid && char_ready) begin
            if (n < 8) got[n] = char_data;
            n++;
         end
         hold  = char_valid && !char_ready;
         hdata = char_data;
         if (print_done) begin
            done = 1'b1;
            gerr = print_err;
         end
         req_valid = c < loads; req_write = 1'b0; req_size = 2'd2; req_signed = 1'b0; req_addr = B + 32'd4;
      end
      req_valid = 1'b0;
      chk({tag, "_done"}, 64'(done), 64'd1);
      chk({tag, "_count"}, 64'(n), 64'(exp_n));
      for (int i = 0; i < exp_n; i++)
         chk($sformatf("%s_char%0d", tag, i), 64'(got[i]), 64'(exp_chars[i*8 +: 8]));
      chk({tag, "_err"}, 64'(gerr), 64'(exp_err));
      if (stall > 0) begin
         chk({tag, "_stall_cycles"}, 64'(nst), 64'(stall));
         chk({tag, "_stable"}, 64'(viol), 64'd0);
      end
      if (loads > 0) begin
         chk({tag, "_cpu_resps"}, 64'(resps), 64'(loads));
         chk({tag, "_cpu_data"}, 64'(bad), 64'd0);
      end
      @(negedge clk);
      chk({tag, "_idle"}, 64'(print_busy), 64'd0);
   endtask

   initial begin
      logic [33:0] r;
      logic ok, pd;
      v[0]  = '{1'b1, 2'd2, 1'b0, B + 32'd4,    32'hDEADBEEF, 1'b0, 32'h0};
      v[1]  = '{1'b0, 2'd0, 1'b1, B + 32'd7,    32'h0,        1'b0, 32'hFFFFFFDE};
      v[2]  = '{1'b0, 2'd1, 1'b0, B + 32'd4,    32'h0,        1'b0, 32'h0000BEEF};
      v[3]  = '{1'b0, 2'd1, 1'b1, B + 32'd6,    32'h0,        1'b0, 32'hFFFFDEAD};
      v[4]  = '{1'b0, 2'd0, 1'b0, B + 32'd5,    32'h0,        1'b0, 32'h000000BE};
      v[5]  = '{1'b0, 2'd2, 1'b0, B + 32'd4,    32'h0,        1'b0, 32'hDEADBEEF};
      v[6]  = '{1'b0, 2'd2, 1'b0, B + 32'd2,    32'h0,        1'b1, 32'h0};
      v[7]  = '{1'b0, 2'd2, 1'b0, B + 32'd4096, 32'h0,        1'b1, 32'h0};
      v[8]  = '{1'b1, 2'd2, 1'b0, B,            32'h11223344, 1'b0, 32'h0};
      v[9]  = '{1'b1, 2'd0, 1'b0, B + 32'd4096, 32'h55,       1'b1, 32'h0};
      v[10] = '{1'b1, 2'd1, 1'b0, B + 32'd1,    32'hA5A5,     1'b1, 32'h0};
      v[11] = '{1'b0, 2'd3, 1'b0, B,            32'h0,        1'b1, 32'h0};
      v[12] = '{1'b0, 2'd2, 1'b0, B,            32'h0,        1'b0, 32'h11223344};
      v[13] = '{1'b1, 2'd0, 1'b0, B + 32'd6,    32'h77,       1'b0, 32'h0};
      v[14] = '{1'b0, 2'd2, 1'b0, B + 32'd4,    32'h0,        1'b0, 32'hDE77BEEF};
      v[15] = '{1'b1, 2'd1, 1'b0, B + 32'd6,    32'h1234CAFE, 1'b0, 32'h0};
      v[16] = '{1'b0, 2'd2, 1'b0, B + 32'd4,    32'h0,        1'b0, 32'hCAFEBEEF};
      v[17] = '{1'b0, 2'd2, 1'b0, B - 32'd4,    32'h0,        1'b1, 32'h0};
      v[18] = '{1'b0, 2'd0, 1'b1, B + 32'd3,    32'h0,        1'b0, 32'h00000011};
      v[19] = '{1'b0, 2'd0, 1'b1, B + 32'd4,    32'h0,        1'b0, 32'hFFFFFFEF};

      repeat (3) @(posedge clk);
      #1;
      chk("reset_outputs", 64'({rd_valid, err, rd_data, char_valid, char_data, print_busy, print_done, print_err}), 64'd0);
      @(negedge clk);
      rst = 1'b0;

      for (int i = 0; i < 20; i++) begin
         access(v[i].wr, v[i].sz, v[i].sg, v[i].a, v[i].wd, r);
         chk($sformatf("vec%0d", i), 64'(r), 64'({1'b1, v[i].e, v[i].d}));
      end

      access(1'b1, 2'd2, 1'b0, B + 32'd12, 32'h12345678, r);
      chk("store_b12", 64'(r), 64'({2'b10, 32'h0}));
      @(negedge clk);
      rst = 1'b1;
      req_valid = 1'b1; req_write = 1'b1; req_size = 2'd2; req_addr = B + 32'd12; req_wdata = 32'hFFFFFFFF;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      chk("rst_store_no_resp", 64'(rd_valid), 64'd0);
      @(negedge clk);
      rst = 1'b0;
      access(1'b0, 2'd2, 1'b0, B + 32'd12, 32'h0, r);
      chk("rst_store_discarded", 64'(r), 64'({2'b10, 32'h12345678}));

      access(1'b1, 2'd2, 1'b0, B + 32'd8, 32'h00216948, r);
      access(1'b1, 2'd2, 1'b0, B + 32'd4092, 32'h44434241, r);
      chk("store_last_word", 64'(r), 64'({2'b10, 32'h0}));

      print_job("hi", B + 32'd8, 0, 0, 32'h0, 32'h00216948, 3, 1'b0);
      print_job("hi_stall", B + 32'd8, 5, 3, 32'hCAFEBEEF, 32'h00216948, 3, 1'b0);
      print_job("last_word", B + 32'd4092, 0, 0, 32'h0, 32'h44434241, 4, 1'b1);

      @(negedge clk);
      print_start = 1'b1; print_addr = B + 32'd8; char_ready = 1'b0;
      @(negedge clk);
      print_start = 1'b0;
      ok = 1'b0;
      for (int c = 0; c < 50 && !ok; c++) begin
         @(negedge clk);
         ok = char_valid;
      end
      chk("emit_reached", 64'(ok), 64'd1);
      rst = 1'b1;
      @(posedge clk);
      #1;
      chk("rst_in_emit", 64'({char_valid, print_busy, print_done, char_data}), 64'd0);
      @(negedge clk);
      rst = 1'b0;
      char_ready = 1'b1;
      pd = 1'b0;
      repeat (6) begin
         @(negedge clk);
         pd = pd | print_done | print_busy;
      end
      chk("no_done_after_rst", 64'(pd), 64'd0);
      print_job("after_rst", B + 32'd8, 0, 0, 32'h0, 32'h00216948, 3, 1'b0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
